// File: rtl/sparserdes_tx_scheduler_if.sv
// Channel request/ack, encoder handshake and serial lane bundle for the sparse-SERDES TX scheduler.
interface sparserdes_tx_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_BITS = $clog2(NUM_CH);

    logic               enable;
    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  ack;
    logic [CH_BITS-1:0] grant_id;
    logic               busy;
    logic               enc_start;
    logic               enc_bit;
    logic               enc_last;
    logic               enc_abort;
    logic               err;
    logic               tx_bit;
    logic               tx_frame;

    modport master (
        input  enable, req, enc_bit, enc_last,
        output ack, grant_id, busy, enc_start, enc_abort, err, tx_bit, tx_frame
    );

    modport slave (
        output enable, req, enc_bit, enc_last,
        input  ack, grant_id, busy, enc_start, enc_abort, err, tx_bit, tx_frame
    );
endinterface

// File: rtl/sparserdes_tx_scheduler.sv
// Round-robin scheduler sharing one sparse-SERDES lane: frames each transfer as
// sync bit, channel-id header, encoder payload (watchdog guarded), idle gap.
module sparserdes_tx_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int MAX_PAYLOAD = 32,
    parameter int GAP_CYCLES  = 2
) (
    input logic clk,
    input logic reset,
    sparserdes_tx_scheduler_if.master bus
);
    localparam int CH_BITS = $clog2(NUM_CH);
    localparam int PW      = $clog2(MAX_PAYLOAD + 1);
    localparam int GW      = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SYNC, HDR, PAYLOAD, GAP} state_t;

    state_t             state, state_nxt;
    logic [CH_BITS-1:0] grant_id, rr_ptr, hdr_idx, pick;
    logic               pick_vld;
    logic [PW-1:0]      pay_cnt;
    logic [GW-1:0]      gap_cnt;
    logic               lane_bit, lane_frame;
    logic               wd_hit, frame_end, wd_fire;

    // First pending request after the last winner, wrapping modulo NUM_CH.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!pick_vld && bus.req[CH_BITS'((int'(rr_ptr) + i) % NUM_CH)]) begin
                pick     = CH_BITS'((int'(rr_ptr) + i) % NUM_CH);
                pick_vld = 1'b1;
            end
        end
    end

    assign wd_hit    = (pay_cnt == PW'(MAX_PAYLOAD - 1));
    assign frame_end = (state == PAYLOAD) && (bus.enc_last || wd_hit);
    assign wd_fire   = (state == PAYLOAD) && !bus.enc_last && wd_hit;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.enable && pick_vld) state_nxt = SYNC;
            SYNC:    state_nxt = HDR;
            HDR:     if (hdr_idx == '0) state_nxt = PAYLOAD;
            PAYLOAD: if (frame_end) state_nxt = GAP;
            GAP:     if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ack       = '0;
        bus.enc_start = (state == HDR) && (hdr_idx == '0);
        bus.enc_abort = wd_fire;
        bus.err       = wd_fire;
        bus.busy      = (state != IDLE);
        lane_bit      = 1'b0;
        lane_frame    = 1'b0;
        if (frame_end) bus.ack[grant_id] = 1'b1;
        case (state)
            SYNC:    begin lane_bit = 1'b1;              lane_frame = 1'b1; end
            HDR:     begin lane_bit = grant_id[hdr_idx]; lane_frame = 1'b1; end
            PAYLOAD: begin lane_bit = bus.enc_bit;       lane_frame = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_id     <= '0;
            rr_ptr       <= CH_BITS'(NUM_CH - 1);
            hdr_idx      <= '0;
            pay_cnt      <= '0;
            gap_cnt      <= '0;
            bus.tx_bit   <= 1'b0;
            bus.tx_frame <= 1'b0;
        end else begin
            bus.tx_bit   <= lane_bit;
            bus.tx_frame <= lane_frame;
            case (state)
                IDLE: if (bus.enable && pick_vld) begin
                    grant_id <= pick;
                    rr_ptr   <= pick;
                end
                SYNC:    hdr_idx <= CH_BITS'(CH_BITS - 1);
                HDR: begin
                    hdr_idx <= hdr_idx - 1'b1;
                    pay_cnt <= '0;
                end
                PAYLOAD: begin
                    pay_cnt <= pay_cnt + 1'b1;
                    gap_cnt <= '0;
                end
                GAP:     gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.grant_id = grant_id;
endmodule
